// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (read-only) and the load/store unit. Data requests normally win; reads go
// through a fixed LAT-cycle pipeline with a single transaction in flight.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch anti-starvation).
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(LAT - 1);

  // Reject illegal configurations at elaboration time.
  if ((LAT < 1) || (LAT > 4)) begin : g_lat_range
    $error("mem_port_arbiter: LAT must be within 1..4");
  end
  if (STARVE_MAX < 1) begin : g_starve_range
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  state_t          state_r;
  logic [LW-1:0]   lat_cnt_r;
  logic            owner_r;      // 0 = fetch, 1 = data
  logic            idle_s;
  logic            done_s;
  logic            starve_hit_s;
  logic            d_win_s;
  logic            if_win_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);
  logic [SW-1:0] starve_cnt_r;
`endif

  // Arbitration: only in IDLE, data first unless fetch has been starved.
  always_comb begin
    idle_s = (state_r == ST_IDLE) && !rst;
    done_s = (state_r == ST_WAIT) && (lat_cnt_r == {LW{1'b0}}) && !rst;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_hit_s = (starve_cnt_r == STARVE_MAX_C);
`else
    starve_hit_s = 1'b0;
`endif
    d_win_s  = idle_s && d_req && !(starve_hit_s && if_req);
    if_win_s = idle_s && if_req && !d_win_s;
  end

  // Memory port and requester handshake outputs; everything is 0 in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = 32'h0000_0000;
    d_rdata   = 32'h0000_0000;
    if (d_win_s) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_win_s) begin
      if_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end else begin
      mem_en    = 1'b0;
    end
    // Read data is passed straight through only in the return cycle.
    if (done_s) begin
      if (owner_r) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end
  end

  // Read sequencer: IDLE -> WAIT for LAT cycles on any read grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lat_cnt_r <= {LW{1'b0}};
      owner_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (d_win_s && !d_we) begin
            owner_r   <= 1'b1;
            lat_cnt_r <= LAT_INIT;
            state_r   <= ST_WAIT;
          end else if (if_win_s) begin
            owner_r   <= 1'b0;
            lat_cnt_r <= LAT_INIT;
            state_r   <= ST_WAIT;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_r == {LW{1'b0}}) begin
            state_r   <= ST_IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r - LW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          lat_cnt_r <= {LW{1'b0}};
        end
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Count data grants taken while fetch waits; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (!if_req || if_gnt) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (d_gnt && (starve_cnt_r != STARVE_MAX_C)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between the fetch unit (read-only) and the load/store unit (read/write) of the multi-cycle RV32I core.
- Owns the memory port and sequences each access through a fixed-latency read pipeline.
- Keeps at most one transaction in flight.
- Returns read data to whichever requester issued the read.

Parameters:
- AW, 8, word-address width of memory port and requester addresses.
- LAT, 1, memory read latency in cycles, legal range 1..4. mem_rdata is valid LAT cycles after the cycle mem_en=1.
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  AW  fetch word address; stable while if_req && !if_gnt
- if_gnt  out  1  single-cycle grant to fetch
- if_rvalid  out  1  single-cycle pulse; if_rdata valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data word address
- d_wdata  in  32  store data
- d_gnt  out  1  single-cycle grant to data
- d_rvalid  out  1  single-cycle pulse; d_rdata valid (loads only)
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, LAT cycles after mem_en

Behaviour:
- Reset: state=IDLE, lat_cnt=0, owner=0, starve_cnt=0.
  - While rst=1, all of these are forced to 0: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata.
- States are IDLE and WAIT.
- IDLE, no requests: all strobes are 0.
- IDLE, any request: arbitrate combinationally in the same cycle.
  - Drive the winner's gnt=1 and mem_en=1.
  - Drive mem_we/mem_addr/mem_wdata from the winner. Fetch always uses mem_we=0 and mem_wdata=0.
- Priority: data wins over fetch when both requests are high.
- Data store grant: the write completes at that edge. State stays IDLE, so back-to-back grants are allowed on the next cycle. No rvalid is produced.
- Read grant (either requester) at cycle T:
  - Latch owner (0=fetch, 1=data) and go to WAIT with lat_cnt=LAT-1.
  - In WAIT, lat_cnt decrements each cycle.
  - At cycle T+LAT (lat_cnt==0), pulse the owner's rvalid. The owner's rdata equals mem_rdata (combinational pass-through). Return to IDLE.
- Next grant after a read is at cycle T+LAT+1 at the earliest.
- While in WAIT: no gnt is issued and mem_en=0. Requests stay pending.
- rdata outputs are 0 whenever the corresponding rvalid=0.
- Reset during WAIT: the in-flight read is dropped and no rvalid is issued. The FSM starts in IDLE on the first cycle after rst deasserts.
- A request deasserted before grant is legal and is simply not served. The arbiter never grants a requester whose req=0.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt (width clog2(STARVE_MAX+1)) increments on each d_gnt issued while if_req=1.
  - It clears on if_gnt and in any cycle with if_req=0.
  - When starve_cnt==STARVE_MAX and both requests are high in IDLE, fetch wins.
  - starve_cnt saturates at STARVE_MAX and never wraps.
- Not defined: strict data priority; no counter logic is present. Fetch can starve indefinitely.

Test Plan:
- Reset then a single fetch, LAT=1: if_req=1, if_addr=0x10, mem_rdata=0x00000013 → if_gnt and mem_en=1 with mem_addr=0x10 in cycle 0; if_rvalid=1 with if_rdata=0x00000013 in cycle 1; if_rvalid=0 otherwise.
- Collision, both requests high in IDLE, d_we=0, d_addr=0x20 → d_gnt=1, if_gnt=0. d_rvalid follows LAT cycles later. if_gnt arrives at the next IDLE cycle with mem_addr=if_addr.
- Store burst: d_req=1, d_we=1 for 3 cycles, addresses 0x01/0x02/0x03, wdata 0xA/0xB/0xC → 3 consecutive d_gnt pulses and mem_we=1 each cycle; no d_rvalid.
- LAT=3 read, then rst asserted at T+2 → no rvalid at T+3. All outputs are 0 during rst. A new request is granted on the first cycle after rst deasserts.
- MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4, d_req held with stores and if_req held → exactly 4 d_gnt pulses, then if_gnt, then d_gnt resumes. Without the macro, no if_gnt occurs while d_req=1.
- Grant hold: if_req asserted during WAIT → if_gnt stays 0 until the cycle after rvalid. Addresses held stable are sampled exactly at grant.
